// File: rtl/router_dest.sv
// Routing stage: pops the input FIFO head, steers each word to one of four
// output FIFOs by its destination field and keeps per-destination word counts.
//
// state  | meaning
// RESET  | held in reset, all outputs cleared
// INIT   | counters held at zero until init drops
// IDLE   | input FIFO empty, nothing moving
// ACTIVE | words are routed while the input FIFO has data
module router_dest #(
    parameter int TAMANO_DATOS = 12,
    parameter int DEST_LSB     = 8,
    parameter int CONT_W       = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [TAMANO_DATOS-1:0] data_in,
    input  logic                    fifo_in_empty,
    input  logic [3:0]              almost_full,
    output logic                    fifo_in_pop,
    output logic [3:0]              push_out,
    output logic [TAMANO_DATOS-1:0] data_out,
    input  logic                    req,
    input  logic [2:0]              idx,
    output logic [CONT_W-1:0]       contador,
    output logic                    contador_valid,
    output logic [3:0]              estado,
    output logic                    idle
);

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              pop;
    logic [1:0]        dest;
    logic [CONT_W-1:0] count [4];

    assign dest = data_in[DEST_LSB+1:DEST_LSB];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RESET;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            ST_RESET: begin
                state_next = init ? ST_INIT : ST_IDLE;
            end
            ST_INIT: begin
                if (!init) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (init)               state_next = ST_INIT;
                else if (!fifo_in_empty) state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init)              state_next = ST_INIT;
                else if (fifo_in_empty) state_next = ST_IDLE;
                // a stalled head word blocks everything behind it
                pop = !fifo_in_empty && !almost_full[dest];
            end
            default: begin
                state_next = ST_RESET;
            end
        endcase
        if (reset) pop = 1'b0;
    end

    assign fifo_in_pop = pop;
    assign estado      = state;
    assign idle        = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            push_out <= 4'b0000;
            data_out <= '0;
        end else if (pop) begin
            push_out <= 4'b0001 << dest;
            data_out <= data_in;
        end else begin
            push_out <= 4'b0000;
        end
    end

    // counts wrap freely; INIT holds them cleared
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (reset || state == ST_INIT) begin
                count[k] <= '0;
            end else if (push_out[k]) begin
                count[k] <= count[k] + CONT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            contador       <= '0;
            contador_valid <= 1'b0;
        end else if (req) begin
            contador_valid <= 1'b1;
            contador       <= (idx[2] || state == ST_INIT) ? '0 : count[idx[1:0]];
        end else begin
            contador_valid <= 1'b0;
        end
    end

endmodule

// File: doc/router_dest.md
Name: router_dest

Overview:
- Routing stage between the input FIFO and the four output FIFOs (FIFO4..FIFO7) of the PCIE path.
- Pops words from the head of the input FIFO and decodes a 2-bit destination field in each word.
- Pushes each word into the selected output FIFO, stalling while that FIFO reports almost_full.
- Keeps per-destination delivered-word counters, readable through the req/idx interface that the probador drives.

Parameters:
- TAMANO_DATOS, 12, data word width.
- DEST_LSB, 8, bit position of the LSB of the 2-bit destination field. Destination = data[DEST_LSB+1:DEST_LSB]; 0 selects FIFO4, 1 FIFO5, 2 FIFO6, 3 FIFO7.
- CONT_W, 5, width of each delivered-word counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- init  input  1  level; requests the INIT state (clears counters).
- data_in  input  TAMANO_DATOS  head word of the input FIFO (first-word-fall-through, valid when fifo_in_empty=0).
- fifo_in_empty  input  1  input FIFO empty.
- almost_full  input  4  bit k = almost_full of FIFO(4+k).
- fifo_in_pop  output  1  combinational pop to the input FIFO.
- push_out  output  4  registered one-hot push; bit k targets FIFO(4+k).
- data_out  output  TAMANO_DATOS  registered word accompanying push_out.
- req  input  1  counter read request.
- idx  input  3  counter index; 0..3 are valid.
- contador  output  CONT_W  registered counter read data.
- contador_valid  output  1  registered; high one cycle after req.
- estado  output  4  one-hot state: RESET=0001, INIT=0010, IDLE=0100, ACTIVE=1000.
- idle  output  1  high while in IDLE.

Behaviour:
- Reset (reset=1 at a clk edge):
  - estado=RESET; push_out=0, data_out=0, contador=0, contador_valid=0, idle=0.
  - All counters cleared. fifo_in_pop forced to 0 while reset=1.
  - reset asserted mid-transfer discards the registered word; no push occurs.
- State transitions:
  - RESET, reset=0: to INIT if init=1, else to IDLE.
  - INIT: counters held at 0; stays while init=1; init=0 goes to IDLE.
  - IDLE: goes to ACTIVE when fifo_in_empty=0.
  - ACTIVE: goes to IDLE when fifo_in_empty=1.
  - IDLE or ACTIVE with init=1: goes to INIT. This has priority over the other transitions. A push already registered still completes and is counted before the clear takes effect.
- Transfer, ACTIVE only:
  - dest = data_in[DEST_LSB+1:DEST_LSB].
  - fifo_in_pop = !fifo_in_empty && !almost_full[dest].
  - On a cycle with pop=1: next edge sets data_out<=data_in and push_out<=(1<<dest); latency 1 cycle; throughput 1 word/cycle.
  - If pop=0, push_out<=0 next edge and data_out holds its last value.
  - Head-of-line blocking: a stalled word blocks all later words, even those for non-full FIFOs.
  - No pop or push in RESET, INIT or IDLE.
- Almost-full rule: almost_full is sampled in the same cycle as the pop. The output FIFO threshold must leave at least 1 entry of slack for the registered push; the router does not check full.
- Counters:
  - count[k] increments by 1 on every cycle with push_out[k]=1.
  - Wraps modulo 2^CONT_W (31 -> 0), no saturation.
- Read:
  - req=1 at an edge gives contador<=count[idx] and contador_valid<=1 at that edge.
  - idx>=4 gives contador=0 with contador_valid=1.
  - req=0 gives contador_valid<=0 and contador holds its value.
  - A read in the same cycle as an increment returns the pre-increment value.
  - A read during INIT returns 0.
- Simultaneous init and req: the read returns the pre-clear value.

Test Plan:
- Reset then init: reset=1 for 2 cycles, then reset=0 with init=1 for 2 cycles, then init=0.
  - Required: estado goes 0001 -> 0010 -> 0100; all outputs 0; contador for idx 0..3 reads 0.
- Routing: push 12'h1FB, 12'h2F6, 12'h3BB, 12'h0C1 into the input FIFO, all almost_full=0.
  - Required: push_out = 0010, 0100, 1000, 0001 on consecutive cycles, each one cycle after its pop.
  - Required: data_out matches each word in order.
- Back-pressure: head word 12'h2F6 with almost_full=4'b0100 held for 5 cycles, then released.
  - Required: fifo_in_pop=0 and push_out=0 for 5 cycles.
  - Required: the word is delivered the cycle after release, with no word lost or duplicated.
  - Required: a following 12'h1FB does not bypass it.
- Counter wrap and read: 33 words to dest 0.
  - Required: req=1 with idx=0 gives contador=1, contador_valid=1 next cycle.
  - Required: idx=5 gives contador=0.
- Mid-stream init: init=1 while words are flowing.
  - Required: the in-flight push completes; estado=0010; no further pops; the next read gives count=0.
  - Required: after init=0, flow resumes through IDLE -> ACTIVE.
- Mid-stream reset: reset=1 on the cycle after a pop.
  - Required: push_out=0 next edge; estado=0001; counters 0.
